// File: rtl/rtc_pkg.sv
// rtc_pkg: RTC register map, burst sizes, state encodings and bus-drive helpers
// shared by rtc_snapshot_reader and rtc_bus_cycle.
package rtc_pkg;

  localparam int N_REG   = 13;
  localparam int N_RELOJ = 9;
  localparam int N_TEMP  = 13;

  typedef enum logic [3:0] {
    IDX_CENTESIMAS     = 4'd0,
    IDX_SEGUNDOS       = 4'd1,
    IDX_MINUTOS        = 4'd2,
    IDX_HORAS          = 4'd3,
    IDX_FECHA          = 4'd4,
    IDX_MES            = 4'd5,
    IDX_ANIO           = 4'd6,
    IDX_DIA_SEMANA     = 4'd7,
    IDX_NUMERO_SEMANA  = 4'd8,
    IDX_CENTESIMAS_T   = 4'd9,
    IDX_SEGUNDOS_T     = 4'd10,
    IDX_MINUTOS_T      = 4'd11,
    IDX_HORAS_T        = 4'd12
  } regIdx_t;

  // RTC bus address of each register, in index order.
  localparam logic [7:0] REG_ADDR [N_REG] = '{
    8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h40, 8'h41, 8'h42, 8'h43
  };

  typedef enum logic [2:0] {PH_IDLE, PH_ADDR, PH_GAP, PH_READ, PH_REL} busPhase_t;
  typedef enum logic [1:0] {B_IDLE, B_RUN, B_DONE} burstState_t;

  typedef struct packed {
    logic       csN;
    logic       rdN;
    logic       wrN;
    logic       aD;
    logic       adOe;
    logic [7:0] adOut;
  } busDrive_t;

  function automatic logic [7:0] regAddr(input logic [3:0] idx);
    return (idx < 4'(N_REG)) ? REG_ADDR[idx] : 8'h00;
  endfunction

  // Pin levels held for the whole of a bus phase; anything not listed is the idle state.
  function automatic busDrive_t busDrive(input busPhase_t phase, input logic [7:0] addr);
    busDrive_t d;
    d = '{csN: 1'b1, rdN: 1'b1, wrN: 1'b1, aD: 1'b1, adOe: 1'b0, adOut: 8'h00};
    case (phase)
      PH_ADDR: begin
        d.csN   = 1'b0;
        d.wrN   = 1'b0;
        d.aD    = 1'b0;
        d.adOe  = 1'b1;
        d.adOut = addr;
      end
      PH_GAP:  d.aD = 1'b0;
      PH_READ: begin
        d.csN = 1'b0;
        d.rdN = 1'b0;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic isBcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: one ADDR/GAP/READ/REL read transaction on the RTC AD bus, PH clocks per phase.
// start is taken while idle or in the last REL cycle, so transactions chain back to back.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic       capture,
  output logic       done,
  output logic [7:0] dato,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  localparam int CW = (PH > 1) ? $clog2(PH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PH - 1);

  busPhase_t     phase;
  logic [CW-1:0] phaseCnt;
  logic          phaseEnd;
  busDrive_t     drive;

  assign phaseEnd = (phaseCnt == LAST);
  // capture marks the edge on which the bus value is taken; dato is that value.
  assign capture  = (phase == PH_READ) && phaseEnd;
  assign done     = (phase == PH_REL) && phaseEnd;
  assign dato     = ad_in;

  // NOTE: all state here is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= PH_IDLE;
      phaseCnt <= '0;
      drive    <= busDrive(PH_IDLE, 8'h00);
    end else begin
      phaseCnt <= (phase == PH_IDLE || phaseEnd) ? '0 : phaseCnt + 1'b1;
      case (phase)
        PH_IDLE: if (start) begin
          phase <= PH_ADDR;
          drive <= busDrive(PH_ADDR, addr);
        end
        PH_ADDR: if (phaseEnd) begin
          phase <= PH_GAP;
          drive <= busDrive(PH_GAP, addr);
        end
        PH_GAP: if (phaseEnd) begin
          phase <= PH_READ;
          drive <= busDrive(PH_READ, addr);
        end
        PH_READ: if (phaseEnd) begin
          phase <= PH_REL;
          drive <= busDrive(PH_REL, addr);
        end
        PH_REL: if (phaseEnd) begin
          if (start) begin
            phase <= PH_ADDR;
            drive <= busDrive(PH_ADDR, addr);
          end else begin
            phase <= PH_IDLE;
            drive <= busDrive(PH_IDLE, addr);
          end
        end
        default: begin
          phase <= PH_IDLE;
          drive <= busDrive(PH_IDLE, 8'h00);
        end
      endcase
    end
  end

  assign ad_out = drive.adOut;
  assign ad_oe  = drive.adOe;
  assign cs_n   = drive.csN;
  assign rd_n   = drive.rdN;
  assign wr_n   = drive.wrN;
  assign a_d    = drive.aD;

endmodule

// File: rtl/rtc_snapshot_reader.sv
// rtc_snapshot_reader: on each tick_frame reads the RTC clock (and timer) registers and streams them out.
// Optional: define RTC_BCD_CHECK_EN to replace non-BCD bytes with the last good value and flag bcd_err.
module rtc_snapshot_reader
  import rtc_pkg::*;
#(
  parameter int PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_frame,
  input  logic       temporizador,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] dato_rtc,
  output logic [3:0] dato_idx,
  output logic       dato_valid,
  output logic       busy,
  output logic       snapshot_done,
  output logic       bcd_err
);

  burstState_t burstState;
  logic [3:0]  idx;
  logic [3:0]  lastIdx;
  logic        more;
  logic        start;
  logic        capture;
  logic        txnDone;
  logic [7:0]  addr;
  logic [7:0]  busDato;
  logic [7:0]  outByte;

  // The burst opens straight from tick_frame so the first ADDR cycle follows the tick edge.
  assign start = ((burstState == B_IDLE) && tick_frame) || ((burstState == B_RUN) && more);
  assign addr  = (burstState == B_IDLE) ? regAddr(IDX_CENTESIMAS) : regAddr(idx);

  rtc_bus_cycle #(.PH(PH)) u_bus (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .addr    (addr),
    .ad_in   (ad_in),
    .capture (capture),
    .done    (txnDone),
    .dato    (busDato),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .a_d     (a_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burstState    <= B_IDLE;
      idx           <= '0;
      lastIdx       <= '0;
      more          <= 1'b0;
      busy          <= 1'b0;
      snapshot_done <= 1'b0;
      dato_valid    <= 1'b0;
      dato_rtc      <= '0;
      dato_idx      <= '0;
    end else begin
      dato_valid    <= 1'b0;
      snapshot_done <= 1'b0;
      case (burstState)
        B_IDLE: if (tick_frame) begin
          burstState <= B_RUN;
          busy       <= 1'b1;
          idx        <= '0;
          more       <= 1'b1;
          lastIdx    <= temporizador ? 4'(N_TEMP - 1) : 4'(N_RELOJ - 1);
        end
        B_RUN: begin
          if (capture) begin
            dato_valid <= 1'b1;
            dato_idx   <= idx;
            dato_rtc   <= outByte;
            idx        <= idx + 4'd1;
            more       <= (idx != lastIdx);
          end
          if (txnDone && !more) begin
            burstState    <= B_DONE;
            busy          <= 1'b0;
            snapshot_done <= 1'b1;
          end
        end
        default: burstState <= B_IDLE;
      endcase
    end
  end

`ifdef RTC_BCD_CHECK_EN
  logic [7:0] shadow [N_REG];
  logic       byteOk;

  assign byteOk  = isBcd(busDato);
  assign outByte = byteOk ? busDato : shadow[idx];

  // NOTE: the shadow file sits behind a reset because its contents are visible on
  // dato_rtc; a memory that is never read before being written would not need one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REG; i++) shadow[i] <= '0;
      bcd_err <= 1'b0;
    end else if ((burstState == B_RUN) && capture) begin
      if (byteOk) shadow[idx] <= busDato;
      else        bcd_err     <= 1'b1;
    end
  end
`else
  assign outByte = busDato;
  assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_snapshot_reader.sv
// Bench for rtc_snapshot_reader: RTC bus model, scoreboard of expected bytes and a bus-protocol monitor.
module tb_rtc_snapshot_reader;

  localparam int PH  = 4;
  localparam int TXN = 4 * PH;
  localparam logic [7:0] TB_ADDR [13] = '{
    8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
    8'h40, 8'h41, 8'h42, 8'h43
  };

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_frame = 1'b0;
  logic       temporizador = 1'b0;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d;
  logic [7:0] dato_rtc;
  logic [3:0] dato_idx;
  logic       dato_valid, busy, snapshot_done, bcd_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int validCount = 0;
  int doneCount = 0;
  exp_t sb[$];
  int   doneQ[$];
  logic [7:0] regData [13];
  logic [7:0] latchedAddr = 8'h00;
  logic errM = 1'b0;
`ifdef RTC_BCD_CHECK_EN
  logic [7:0] shadowM [13];
  function automatic logic bcdOk(input logic [7:0] b);
    return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
  endfunction
`endif

  rtc_snapshot_reader #(.PH(PH)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_frame    (tick_frame),
    .temporizador  (temporizador),
    .ad_in         (ad_in),
    .ad_out        (ad_out),
    .ad_oe         (ad_oe),
    .cs_n          (cs_n),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .a_d           (a_d),
    .dato_rtc      (dato_rtc),
    .dato_idx      (dato_idx),
    .dato_valid    (dato_valid),
    .busy          (busy),
    .snapshot_done (snapshot_done),
    .bcd_err       (bcd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: returns the register whose address was latched in the last address phase.
  always_comb begin
    ad_in = 8'h00;
    if (!cs_n && !rd_n) begin
      ad_in = 8'hEE;
      for (int i = 0; i < 13; i++) if (TB_ADDR[i] == latchedAddr) ad_in = regData[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: bus protocol, phase lengths, scoreboard pops on dato_valid / snapshot_done.
  initial begin
    int runLen;
    logic [4:0] runKey;
    logic [4:0] key;
    logic [7:0] expData;
    exp_t e;
    runLen = 0;
    runKey = '0;
    forever begin
      @(negedge clk);
      if (!cs_n && !wr_n) latchedAddr = ad_out;
      if (reset) begin
        runLen = 0;
      end else begin
        if (!rd_n) check("oe_during_read", ad_oe, 1'b0);
        if (!rd_n || !wr_n) check("rd_wr_exclusive", rd_n | wr_n, 1'b1);
        if (!cs_n && !wr_n) begin
          if (sb.size() == 0) check("addr_without_pending", sb.size(), 1);
          else check("addr_phase", ad_out, TB_ADDR[sb[0].idx]);
        end
        key = {cs_n, rd_n, wr_n, a_d, ad_oe};
        if (busy) begin
          if (runLen != 0 && key != runKey) begin
            check("phase_len", runLen, PH);
            runLen = 0;
          end
          runKey = key;
          runLen++;
        end else if (runLen != 0) begin
          check("phase_len", runLen, PH);
          runLen = 0;
        end
        if (dato_valid) begin
          validCount++;
          if (sb.size() == 0) begin
            check("valid_unexpected", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            expData = e.data;
`ifdef RTC_BCD_CHECK_EN
            if (bcdOk(e.data)) shadowM[e.idx] = e.data;
            else begin
              expData = shadowM[e.idx];
              errM = 1'b1;
            end
`endif
            check("dato_idx", dato_idx, e.idx);
            check("dato_rtc", dato_rtc, expData);
            check("valid_cycle", cyc, e.cyc);
            check("bcd_err", bcd_err, errM);
            check("busy_at_valid", busy, 1'b1);
          end
        end
        if (snapshot_done) begin
          doneCount++;
          if (doneQ.size() == 0) check("done_unexpected", doneQ.size(), 1);
          else check("done_cycle", cyc, doneQ.pop_front());
          check("busy_at_done", busy, 1'b0);
        end
      end
    end
  end

  task automatic startBurst(input logic tmr);
    int   n;
    exp_t e;
    temporizador = tmr;
    @(posedge clk);
    #1;
    tick_frame = 1'b1;
    t0 = cyc;
    n = tmr ? 13 : 9;
    for (int k = 0; k < n; k++) begin
      e.idx  = k;
      e.data = regData[k];
      e.cyc  = t0 + 1 + TXN * k + 3 * PH;
      sb.push_back(e);
    end
    doneQ.push_back(t0 + 1 + TXN * n);
    @(posedge clk);
    #1;
    tick_frame = 1'b0;
  endtask

  task automatic waitRel(input int rel);
    while ((cyc - t0) < rel) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int d0, input string tag);
    int n;
    n = 0;
    while (doneCount == d0 && n < TXN * 13 + 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, doneCount > d0, 1'b1);
  endtask

  task automatic runBurst(input logic tmr, input string tag);
    int d0, v0;
    d0 = doneCount;
    v0 = validCount;
    startBurst(tmr);
    waitDone(d0, tag);
    repeat (4) @(negedge clk);
    check({tag, "_strobes"}, validCount - v0, tmr ? 13 : 9);
  endtask

  initial begin
    int d0, v0;
    for (int i = 0; i < 13; i++) regData[i] = 8'h10 + 8'(i);
`ifdef RTC_BCD_CHECK_EN
    for (int i = 0; i < 13; i++) shadowM[i] = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_rd_n", rd_n, 1'b1);
    check("rst_wr_n", wr_n, 1'b1);
    check("rst_a_d", a_d, 1'b1);
    check("rst_ad_oe", ad_oe, 1'b0);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", dato_valid, 1'b0);
    check("rst_done", snapshot_done, 1'b0);
    check("rst_dato_rtc", dato_rtc, 8'h00);
    check("rst_dato_idx", dato_idx, 4'h0);
    check("rst_bcd_err", bcd_err, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Clock-only burst with a second tick at cycle 50 that must be ignored.
    d0 = doneCount;
    v0 = validCount;
    startBurst(1'b0);
    waitRel(50);
    tick_frame = 1'b1;
    @(posedge clk);
    #1;
    tick_frame = 1'b0;
    waitDone(d0, "clock");
    repeat (40) @(negedge clk);
    check("clock_strobes", validCount - v0, 9);
    check("clock_one_done", doneCount - d0, 1);
    check("clock_sb_empty", sb.size(), 0);
    check("idle_busy", busy, 1'b0);

    // Timer burst; temporizador toggles mid-burst without changing the count.
    d0 = doneCount;
    v0 = validCount;
    startBurst(1'b1);
    waitRel(30);
    temporizador = 1'b0;
    waitRel(100);
    temporizador = 1'b1;
    waitRel(150);
    temporizador = 1'b0;
    waitDone(d0, "timer");
    repeat (2) @(negedge clk);
    check("timer_strobes", validCount - v0, 13);
    check("timer_sb_empty", sb.size(), 0);

    // Reset in the READ phase of register 4, then a fresh burst.
    startBurst(1'b0);
    waitRel(1 + 4 * TXN + 2 * PH + 1);
    check("pre_reset_in_read", rd_n, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cs_n", cs_n, 1'b1);
    check("mid_rst_rd_n", rd_n, 1'b1);
    check("mid_rst_ad_oe", ad_oe, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_a_d", a_d, 1'b1);
    sb.delete();
    doneQ.delete();
    errM = 1'b0;
`ifdef RTC_BCD_CHECK_EN
    for (int i = 0; i < 13; i++) shadowM[i] = 8'h00;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_dato_idx", dato_idx, 4'h0);
    check("post_rst_dato_rtc", dato_rtc, 8'h00);
    check("post_rst_bcd_err", bcd_err, 1'b0);
    for (int i = 0; i < 13; i++) regData[i] = 8'h30 + 8'(i);
    runBurst(1'b0, "after_reset");

    // Non-BCD byte for index 2 after a good one; the sticky flag must survive later bursts.
    regData[2] = 8'h37;
    runBurst(1'b0, "bcd_good");
    regData[2] = 8'h5A;
    runBurst(1'b0, "bcd_bad");
    regData[2] = 8'h45;
    runBurst(1'b0, "bcd_after");
    check("final_bcd_err", bcd_err, errM);
    check("final_sb_empty", sb.size(), 0);
    check("final_doneq_empty", doneQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
